// File: rtl/inject_pkg.sv
// Shared definitions for the credit-based task injection stream.
// The receiver FSM states and the header/word geometry live here.
package inject_pkg;

    typedef enum logic [2:0] {
        S_TEXT,
        S_DATA,
        S_BSS,
        S_ENTRY,
        S_PAYLOAD,
        S_DRAIN,
        S_ZERO,
        S_DONE
    } state_t;

    localparam int HEADER_FLITS = 4;
    localparam int WORD_BYTES   = 4;
    localparam int WORD_SHIFT   = $clog2(WORD_BYTES);

endpackage

// File: rtl/task_image_receiver.sv
// Receives one task image per packet (4 header flits + binary words), writes it
// into local memory, zero-fills BSS and reports completion or overflow.
module task_image_receiver
    import inject_pkg::*;
#(
    parameter int FLIT_SIZE  = 32,
    parameter int MEM_BYTES  = 65536,
    parameter int ADDR_WIDTH = $clog2(MEM_BYTES / 4)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    output logic                  credit_o,
    input  logic [FLIT_SIZE-1:0]  data_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [FLIT_SIZE-1:0]  mem_data_o,
    output logic [FLIT_SIZE-1:0]  text_size_o,
    output logic [FLIT_SIZE-1:0]  data_size_o,
    output logic [FLIT_SIZE-1:0]  bss_size_o,
    output logic [FLIT_SIZE-1:0]  entry_point_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [FLIT_SIZE+1:0] MEM_LIMIT = (FLIT_SIZE + 2)'(MEM_BYTES);

    state_t                state;
    state_t                state_next;
    logic                  xfer;
    logic [ADDR_WIDTH:0]   addr_cnt;
    logic [FLIT_SIZE-1:0]  remaining;
    logic                  last;
    logic [FLIT_SIZE:0]    image_bytes;
    logic [FLIT_SIZE:0]    image_words;
    logic [FLIT_SIZE-1:0]  bss_words;
    logic [FLIT_SIZE+1:0]  total_bytes;
    logic                  overflow;
    logic                  has_words;
    logic                  has_bss;

    // Credit is withheld only while the receiver is busy on its own (zero fill, done).
    assign credit_o = (state != S_ZERO) && (state != S_DONE);
    assign xfer     = rx_i && credit_o;
    assign busy_o   = (state != S_TEXT);
    assign done_o   = (state == S_DONE);

    // Sizes are all latched by the time the entry flit arrives, so these are stable in S_ENTRY.
    assign image_bytes = {1'b0, text_size_o} + {1'b0, data_size_o};
    assign image_words = image_bytes >> WORD_SHIFT;
    assign bss_words   = bss_size_o >> WORD_SHIFT;
    assign total_bytes = {2'b00, text_size_o} + {2'b00, data_size_o} + {2'b00, bss_size_o};
    assign overflow    = (total_bytes > MEM_LIMIT);
    assign has_words   = (image_words != '0);
    assign has_bss     = (bss_words != '0);
    assign last        = (remaining == FLIT_SIZE'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_TEXT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_TEXT:    if (xfer) state_next = S_DATA;
            S_DATA:    if (xfer) state_next = S_BSS;
            S_BSS:     if (xfer) state_next = S_ENTRY;
            S_ENTRY: begin
                if (xfer) begin
                    if (overflow)       state_next = has_words ? S_DRAIN : S_DONE;
                    else if (has_words) state_next = S_PAYLOAD;
                    else if (has_bss)   state_next = S_ZERO;
                    else                state_next = S_DONE;
                end
            end
            S_PAYLOAD: if (xfer && last) state_next = has_bss ? S_ZERO : S_DONE;
            S_DRAIN:   if (xfer && last) state_next = S_DONE;
            S_ZERO:    if (last) state_next = S_DONE;
            S_DONE:    state_next = S_TEXT;
            default:   state_next = S_TEXT;
        endcase
    end

    // Header latches, word/remaining counters and the registered memory write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            text_size_o   <= '0;
            data_size_o   <= '0;
            bss_size_o    <= '0;
            entry_point_o <= '0;
            error_o       <= 1'b0;
            addr_cnt      <= '0;
            remaining     <= '0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_data_o    <= '0;
        end else begin
            mem_we_o <= 1'b0;
            case (state)
                S_TEXT: begin
                    if (xfer) begin
                        text_size_o <= data_i;
                        error_o     <= 1'b0;
                        addr_cnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) data_size_o <= data_i;
                end
                S_BSS: begin
                    if (xfer) bss_size_o <= data_i;
                end
                S_ENTRY: begin
                    if (xfer) begin
                        entry_point_o <= data_i;
                        if (overflow) begin
                            error_o   <= 1'b1;
                            remaining <= image_words[FLIT_SIZE-1:0];
                        end else if (has_words) begin
                            remaining <= image_words[FLIT_SIZE-1:0];
                        end else begin
                            remaining <= bss_words;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (xfer) begin
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= addr_cnt[ADDR_WIDTH-1:0];
                        mem_data_o <= data_i;
                        addr_cnt   <= addr_cnt + (ADDR_WIDTH + 1)'(1);
                        remaining  <= last ? bss_words : remaining - FLIT_SIZE'(1);
                    end
                end
                S_DRAIN: begin
                    if (xfer) remaining <= remaining - FLIT_SIZE'(1);
                end
                S_ZERO: begin
                    mem_we_o   <= 1'b1;
                    mem_addr_o <= addr_cnt[ADDR_WIDTH-1:0];
                    mem_data_o <= '0;
                    addr_cnt   <= addr_cnt + (ADDR_WIDTH + 1)'(1);
                    remaining  <= remaining - FLIT_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
